fade_stream_ctrl: RTL and testbench

Parametrised frame sequencer and stream adapter between the fader and the fade IFFT. It generates the periodic start pulse and time index for the fader and runs the one-shot IFFT config handshake, with re-config on request. It packs the fader's channel-serial output into an AXI-Stream frame with tlast on the last channel, and buffers it in a FIFO with backpressure, overflow detection and channel-order checking.

---
 rtl/fade_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fade_stream_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fade_stream_ctrl.sv
// rtl/fade_stream_ctrl.sv - frame sequencer, IFFT config handshake and fader-to-AXIS FIFO adapter
module fade_stream_ctrl #(
  parameter int NCHAN      = 32,
  parameter int CHAN_W     = 5,
  parameter int DATA_W     = 16,
  parameter int TIDX_W     = 25,
  parameter int PERIOD_W   = 10,
  parameter int FIFO_DEPTH = 64,
  parameter int CFG_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_req,
  input  logic                err_clr,
  output logic                start,
  output logic [TIDX_W-1:0]   t_index,
  input  logic                dv_in,
  input  logic [CHAN_W-1:0]   chan_in,
  input  logic [DATA_W-1:0]   din_real,
  input  logic [DATA_W-1:0]   din_imag,
  output logic [CFG_W-1:0]    m_axis_config_tdata,
  output logic                m_axis_config_tvalid,
  input  logic                m_axis_config_tready,
  output logic [2*DATA_W-1:0] m_axis_data_tdata,
  output logic                m_axis_data_tvalid,
  input  logic                m_axis_data_tready,
  output logic                m_axis_data_tlast,
  output logic                overflow,
  output logic                chan_err,
  output logic [31:0]         frame_count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int WORD_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {S_CONFIG, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic [TIDX_W-1:0]   r_idx;
  logic [TIDX_W-1:0]   r_t_index;
  logic                r_start;
  logic                r_cfg_valid;
  logic [CFG_W-1:0]    r_cfg_data;
  logic                r_cfg_pend;
  logic [CHAN_W:0]     r_quiet;

  logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [CHAN_W-1:0]   r_exp_chan;
  logic                r_overflow;
  logic                r_chan_err;
  logic [31:0]         r_frame_count;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_quiet;
  logic [WORD_W-1:0]   w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop   = !w_empty && m_axis_data_tready;
  assign w_push  = dv_in && (!w_full || w_pop);
  assign w_quiet = (r_quiet == (CHAN_W+1)'(NCHAN));

  // Sequencer: the config word is latched once per CONFIG visit and held until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CONFIG;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_t_index   <= '0;
      r_start     <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_cfg_data  <= '0;
      r_cfg_pend  <= 1'b0;
      r_quiet     <= '0;
    end else begin
      r_start <= 1'b0;
      if (dv_in)
        r_quiet <= '0;
      else if (!w_quiet)
        r_quiet <= r_quiet + (CHAN_W+1)'(1);
      if (cfg_req && r_state == S_RUN)
        r_cfg_pend <= 1'b1;
      case (r_state)
        S_CONFIG: begin
          if (!r_cfg_valid) begin
            r_cfg_valid <= 1'b1;
            r_cfg_data  <= cfg_data;
          end else if (m_axis_config_tready) begin
            r_cfg_valid <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - PERIOD_W'(1);
          end else if (r_cfg_pend) begin
            r_state <= S_DRAIN;
          end else if (enable) begin
            r_start   <= 1'b1;
            r_t_index <= r_idx;
            r_idx     <= r_idx + TIDX_W'(1);
            r_cnt     <= period - PERIOD_W'(1);
          end
        end
        S_DRAIN: begin
          // Leave only once the IFFT has consumed the whole frame and the fader has gone idle.
          if (w_empty && w_quiet) begin
            r_state     <= S_CONFIG;
            r_cfg_valid <= 1'b1;
            r_cfg_data  <= cfg_data;
            r_cfg_pend  <= 1'b0;
          end
        end
        default: r_state <= S_CONFIG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= {din_imag, din_real, &chan_in};
  end

  // A same-cycle set beats err_clr so no error event can be lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_exp_chan    <= '0;
      r_overflow    <= 1'b0;
      r_chan_err    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (dv_in)
        r_exp_chan <= chan_in + CHAN_W'(1);
      if (dv_in && !w_push)
        r_overflow <= 1'b1;
      else if (err_clr)
        r_overflow <= 1'b0;
      if (dv_in && chan_in != r_exp_chan)
        r_chan_err <= 1'b1;
      else if (err_clr)
        r_chan_err <= 1'b0;
      if (w_pop && w_head[0])
        r_frame_count <= r_frame_count + 32'd1;
    end
  end

  assign start                = r_start;
  assign t_index              = r_t_index;
  assign m_axis_config_tdata  = r_cfg_data;
  assign m_axis_config_tvalid = r_cfg_valid;
  assign m_axis_data_tdata    = w_head[WORD_W-1:1];
  assign m_axis_data_tvalid   = !w_empty;
  assign m_axis_data_tlast    = !w_empty && w_head[0];
  assign overflow             = r_overflow;
  assign chan_err             = r_chan_err;
  assign frame_count          = r_frame_count;

endmodule

// File: tb/tb_fade_stream_ctrl.sv
// tb/tb_fade_stream_ctrl.sv - scoreboard bench for fade_stream_ctrl
`timescale 1ns/1ps
module tb_fade_stream_ctrl;
  localparam int NCHAN = 32, CHAN_W = 5, DATA_W = 16, TIDX_W = 25;
  localparam int PERIOD_W = 10, FIFO_DEPTH = 64, CFG_W = 16;

  logic                clk = 1'b0;
  logic                reset, enable, cfg_req, err_clr, dv_in;
  logic [PERIOD_W-1:0] period;
  logic [CFG_W-1:0]    cfg_data;
  logic [CHAN_W-1:0]   chan_in;
  logic [DATA_W-1:0]   din_real, din_imag;
  logic                start;
  logic [TIDX_W-1:0]   t_index;
  logic [CFG_W-1:0]    m_axis_config_tdata;
  logic                m_axis_config_tvalid, m_axis_config_tready;
  logic [2*DATA_W-1:0] m_axis_data_tdata;
  logic                m_axis_data_tvalid, m_axis_data_tready, m_axis_data_tlast;
  logic                overflow, chan_err;
  logic [31:0]         frame_count;

  always #5 clk = ~clk;

  fade_stream_ctrl #(
    .NCHAN(NCHAN), .CHAN_W(CHAN_W), .DATA_W(DATA_W), .TIDX_W(TIDX_W),
    .PERIOD_W(PERIOD_W), .FIFO_DEPTH(FIFO_DEPTH), .CFG_W(CFG_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .cfg_data(cfg_data), .cfg_req(cfg_req), .err_clr(err_clr),
    .start(start), .t_index(t_index),
    .dv_in(dv_in), .chan_in(chan_in), .din_real(din_real), .din_imag(din_imag),
    .m_axis_config_tdata(m_axis_config_tdata), .m_axis_config_tvalid(m_axis_config_tvalid),
    .m_axis_config_tready(m_axis_config_tready),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
    .m_axis_data_tready(m_axis_data_tready), .m_axis_data_tlast(m_axis_data_tlast),
    .overflow(overflow), .chan_err(chan_err), .frame_count(frame_count)
  );

  int checks = 0, failures = 0, beats = 0, cyc = 0;
  logic [2*DATA_W:0]  sb[$];
  logic [CFG_W-1:0]   cfg_q[$];
  int                 cfg_cyc_q[$];
  logic [TIDX_W-1:0]  st_idx_q[$];
  int                 st_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && start) begin
      st_idx_q.push_back(t_index);
      st_cyc_q.push_back(cyc);
    end
    if (!reset && m_axis_config_tvalid && m_axis_config_tready) begin
      cfg_q.push_back(m_axis_config_tdata);
      cfg_cyc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    logic [2*DATA_W:0] exp_w;
    if (!reset && m_axis_data_tvalid && m_axis_data_tready) begin
      beats++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: got tdata=%h tlast=%b, required no beat", m_axis_data_tdata, m_axis_data_tlast);
      end else begin
        exp_w = sb.pop_front();
        if ({m_axis_data_tdata, m_axis_data_tlast} !== exp_w) begin
          failures++;
          $display("FAIL beat_data: got %h/%b required %h/%b", m_axis_data_tdata, m_axis_data_tlast,
                   exp_w[2*DATA_W:1], exp_w[0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic [CHAN_W-1:0] ch, input bit push);
    logic [DATA_W-1:0] re, im;
    re = DATA_W'($urandom);
    im = DATA_W'($urandom);
    dv_in = 1'b1; chan_in = ch; din_real = re; din_imag = im;
    if (push) sb.push_back({im, re, ch == CHAN_W'(NCHAN - 1)});
    tick(1);
  endtask

  task automatic wait_start(input int budget, output bit ok);
    int n0;
    n0 = st_idx_q.size();
    for (int i = 0; i < budget && st_idx_q.size() == n0; i++) tick(1);
    ok = (st_idx_q.size() > n0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
    tick(2);
  endtask

  task automatic test_reset;
    bit ok;
    reset = 1; enable = 1; period = '0; cfg_data = 16'h0AAC; cfg_req = 0; err_clr = 0;
    dv_in = 0; chan_in = '0; din_real = '0; din_imag = '0;
    m_axis_config_tready = 0; m_axis_data_tready = 1;
    tick(3);
    checks++;
    if ({start, t_index, m_axis_config_tvalid, m_axis_data_tvalid, m_axis_data_tlast} !== '0) begin
      failures++;
      $display("FAIL reset_outs: got start=%b tidx=%0d cfgv=%b dv=%b tlast=%b required all 0",
               start, t_index, m_axis_config_tvalid, m_axis_data_tvalid, m_axis_data_tlast);
    end
    checks++;
    if ({overflow, chan_err, frame_count} !== '0) begin
      failures++;
      $display("FAIL reset_flags: got ovf=%b cerr=%b fc=%0d required 0", overflow, chan_err, frame_count);
    end
    reset = 0;
    tick(3);
    checks++;
    if (m_axis_config_tvalid !== 1'b1 || m_axis_config_tdata !== 16'h0AAC) begin
      failures++;
      $display("FAIL cfg_hold: got v=%b d=%h required 1/0aac", m_axis_config_tvalid, m_axis_config_tdata);
    end
    m_axis_config_tready = 1;
    for (int i = 0; i < 10 && cfg_q.size() == 0; i++) tick(1);
    checks++;
    if (cfg_q.size() !== 1 || cfg_q[0] !== 16'h0AAC) begin
      failures++;
      $display("FAIL cfg_beat: got n=%0d required 1 beat of 0aac", cfg_q.size());
    end
    wait_start(10, ok);
    checks++;
    if (!ok || st_idx_q[0] !== '0 || st_cyc_q[0] - cfg_cyc_q[0] != 2) begin
      failures++;
      $display("FAIL first_start: got ok=%b, required t_index 0 two cycles after config beat", ok);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_start(1100, ok);
      checks++;
      if (!ok || st_idx_q[k] !== TIDX_W'(k) || st_cyc_q[k] - st_cyc_q[k-1] != 1024) begin
        failures++;
        $display("FAIL start_period0_%0d: got ok=%b, required t_index %0d after 1024 cycles", k, ok, k);
      end
    end
    checks++;
    if (cfg_q.size() != 1) begin
      failures++;
      $display("FAIL cfg_once: got %0d config beats required 1", cfg_q.size());
    end
  endtask

  task automatic test_frames;
    bit ok;
    period = 10'd40;
    for (int f = 0; f < 3; f++) begin
      wait_start(1100, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL frame_start_%0d: got no start, required one", f);
      end
      for (int c = 0; c < NCHAN; c++) drive_sample(CHAN_W'(c), 1'b1);
      dv_in = 0;
    end
    wait_drain(100);
    checks++;
    if (sb.size() != 0 || beats != 96 || frame_count !== 32'd3) begin
      failures++;
      $display("FAIL frames: got left=%0d beats=%0d fc=%0d required 0/96/3", sb.size(), beats, frame_count);
    end
  endtask

  task automatic test_enable_hold;
    int n;
    enable = 0;
    tick(2);
    n = st_idx_q.size();
    tick(200);
    checks++;
    if (st_idx_q.size() != n) begin
      failures++;
      $display("FAIL enable_hold: got %0d starts required 0", st_idx_q.size() - n);
    end
  endtask

  task automatic test_overflow;
    int b0;
    b0 = beats;
    m_axis_data_tready = 0;
    for (int i = 0; i < 4 * NCHAN; i++) drive_sample(CHAN_W'(i % NCHAN), i < FIFO_DEPTH);
    dv_in = 0;
    tick(2);
    checks++;
    if (overflow !== 1'b1 || m_axis_data_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got ovf=%b tvalid=%b required 1/1", overflow, m_axis_data_tvalid);
    end
    tick(5);
    checks++;
    if ({m_axis_data_tdata, m_axis_data_tlast} !== sb[0]) begin
      failures++;
      $display("FAIL stall_stable: got %h required %h", {m_axis_data_tdata, m_axis_data_tlast}, sb[0]);
    end
    m_axis_data_tready = 1;
    wait_drain(200);
    checks++;
    if (sb.size() != 0 || beats - b0 != FIFO_DEPTH || frame_count !== 32'd5 || chan_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain: got left=%0d beats=%0d fc=%0d cerr=%b required 0/64/5/0",
               sb.size(), beats - b0, frame_count, chan_err);
    end
    err_clr = 1; tick(1); err_clr = 0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: got %b required 0", overflow);
    end
  endtask

  task automatic test_chan_err;
    for (int c = 0; c < NCHAN; c++) begin
      if (c == 10) continue;
      if (c == 11) begin
        checks++;
        if (chan_err !== 1'b0) begin
          failures++;
          $display("FAIL cerr_early: got %b required 0", chan_err);
        end
      end
      if (c == 12) begin
        checks++;
        if (chan_err !== 1'b1) begin
          failures++;
          $display("FAIL cerr_set: got %b required 1", chan_err);
        end
      end
      drive_sample(CHAN_W'(c), 1'b1);
    end
    dv_in = 0;
    wait_drain(100);
    checks++;
    if (sb.size() != 0 || frame_count !== 32'd6) begin
      failures++;
      $display("FAIL cerr_frame: got left=%0d fc=%0d required 0/6", sb.size(), frame_count);
    end
    err_clr = 1; tick(1); err_clr = 0;
    checks++;
    if (chan_err !== 1'b0) begin
      failures++;
      $display("FAIL cerr_clr: got %b required 0", chan_err);
    end
  endtask

  task automatic test_cfg_req;
    bit ok;
    int n_cfg, n_st;
    logic [TIDX_W-1:0] k;
    cfg_data = 16'h0556; enable = 1;
    n_cfg = cfg_q.size();
    wait_start(10, ok);
    k = st_idx_q[st_idx_q.size() - 1];
    for (int c = 0; c < NCHAN; c++) begin
      cfg_req = (c == 15);
      drive_sample(CHAN_W'(c), 1'b1);
    end
    cfg_req = 0; dv_in = 0;
    n_st = st_idx_q.size();
    tick(18);
    cfg_req = 1; tick(1); cfg_req = 0;
    for (int i = 0; i < 200 && cfg_q.size() == n_cfg; i++) tick(1);
    checks++;
    if (!ok || cfg_q.size() != n_cfg + 1 || cfg_q[cfg_q.size() - 1] !== 16'h0556 || st_idx_q.size() != n_st) begin
      failures++;
      $display("FAIL reconfig: got ok=%b cfgs=%0d starts=%0d required 1 beat of 0556 and no start",
               ok, cfg_q.size() - n_cfg, st_idx_q.size() - n_st);
    end
    for (int j = 1; j <= 2; j++) begin
      wait_start(100, ok);
      checks++;
      if (!ok || st_idx_q[st_idx_q.size() - 1] !== k + TIDX_W'(j)) begin
        failures++;
        $display("FAIL resume_%0d: got ok=%b, required t_index %0d", j, ok, k + TIDX_W'(j));
      end
    end
    checks++;
    if (cfg_q.size() != n_cfg + 1 || sb.size() != 0 || frame_count !== 32'd7) begin
      failures++;
      $display("FAIL reconfig_once: got cfgs=%0d left=%0d fc=%0d required 1/0/7",
               cfg_q.size() - n_cfg, sb.size(), frame_count);
    end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int b0, n_cfg;
    m_axis_data_tready = 0;
    wait_start(60, ok);
    b0 = beats;
    for (int c = 0; c < 15; c++) drive_sample(CHAN_W'(c), 1'b0);
    reset = 1; cfg_data = 16'h1234;
    drive_sample(CHAN_W'(15), 1'b0);
    dv_in = 0;
    checks++;
    if ({start, t_index, m_axis_config_tvalid, m_axis_data_tvalid, m_axis_data_tlast,
         overflow, chan_err, frame_count} !== '0) begin
      failures++;
      $display("FAIL midreset_outs: got tvalid=%b fc=%0d tidx=%0d required all 0",
               m_axis_data_tvalid, frame_count, t_index);
    end
    n_cfg = cfg_q.size();
    reset = 0; m_axis_data_tready = 1;
    for (int i = 0; i < 20 && cfg_q.size() == n_cfg; i++) tick(1);
    checks++;
    if (cfg_q.size() != n_cfg + 1 || cfg_q[cfg_q.size() - 1] !== 16'h1234) begin
      failures++;
      $display("FAIL midreset_cfg: got %0d beats required 1 of 1234", cfg_q.size() - n_cfg);
    end
    wait_start(10, ok);
    checks++;
    if (!ok || st_idx_q[st_idx_q.size() - 1] !== '0) begin
      failures++;
      $display("FAIL midreset_tidx: got ok=%b, required t_index 0", ok);
    end
    tick(40);
    checks++;
    if (beats != b0) begin
      failures++;
      $display("FAIL midreset_nobeat: got %0d beats required 0", beats - b0);
    end
  endtask

  initial begin
    test_reset;
    test_frames;
    test_enable_hold;
    test_overflow;
    test_chan_err;
    test_cfg_req;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
